// File: rtl/seg_scan_mux.sv
// Eight-digit seven-segment scan controller: prescaled digit rotation with a
// double-buffered value/dp pair that is only swapped in at frame boundaries.
module seg_scan_mux #(
  parameter int PRESCALE = 12500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] value_in,
  input  logic [7:0]  dp_in,
  input  logic [7:0]  digit_en,
  input  logic        blank_lz,
  output logic [3:0]  nibble_out,
  output logic [7:0]  an_out,
  output logic        dp_out,
  output logic [2:0]  digit_idx,
  output logic        frame_start,
  output logic        pending
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   sh_val_q, sh_val_d, act_val_q, act_val_d;
  logic [7:0]    sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
  logic          pend_q, pend_d;
  logic [7:0]    an_q, an_d;
  logic [3:0]    nib_q, nib_d;
  logic          dp_q, dp_d;
  logic          fs_q, fs_d;

  logic          tick, wrap, blanked;
  logic [7:0]    live;
  logic [2:0]    msd;

  assign tick = (cnt_q == CW'(PRESCALE - 1));
  assign wrap = tick && (idx_q == 3'd7);

  // A digit is "live" if it carries a nonzero nibble or a lit decimal point.
  for (genvar gi = 0; gi < 8; gi++) begin : g_live
    assign live[gi] = (act_val_d[4*gi +: 4] != 4'd0) || act_dp_d[gi];
  end

  always_comb begin
    msd = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (live[i]) msd = 3'(i);
    end
  end

  always_comb begin
    cnt_d     = tick ? '0 : cnt_q + 1'b1;
    idx_d     = tick ? idx_q + 3'd1 : idx_q;
    // Transfer reads the old shadow, so a load in the wrap cycle stays pending.
    act_val_d = (wrap && pend_q) ? sh_val_q : act_val_q;
    act_dp_d  = (wrap && pend_q) ? sh_dp_q  : act_dp_q;
    sh_val_d  = load ? value_in : sh_val_q;
    sh_dp_d   = load ? dp_in    : sh_dp_q;
    pend_d    = load ? 1'b1 : (wrap ? 1'b0 : pend_q);
    fs_d      = wrap;

    blanked   = !digit_en[idx_d] || (blank_lz && (idx_d > msd));
    an_d      = an_q;
    nib_d     = nib_q;
    dp_d      = dp_q;
    if (tick) begin
      nib_d = act_val_d[{idx_d, 2'b00} +: 4];
      an_d  = blanked ? 8'hFF : ~(8'h01 << idx_d);
      dp_d  = blanked ? 1'b1 : ~act_dp_d[idx_d];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      idx_q     <= 3'd7;
      sh_val_q  <= '0;
      sh_dp_q   <= '0;
      act_val_q <= '0;
      act_dp_q  <= '0;
      pend_q    <= 1'b0;
      an_q      <= 8'hFF;
      nib_q     <= 4'd0;
      dp_q      <= 1'b1;
      fs_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      sh_val_q  <= sh_val_d;
      sh_dp_q   <= sh_dp_d;
      act_val_q <= act_val_d;
      act_dp_q  <= act_dp_d;
      pend_q    <= pend_d;
      an_q      <= an_d;
      nib_q     <= nib_d;
      dp_q      <= dp_d;
      fs_q      <= fs_d;
    end
  end

  assign nibble_out  = nib_q;
  assign an_out      = an_q;
  assign dp_out      = dp_q;
  assign digit_idx   = idx_q;
  assign frame_start = fs_q;
  assign pending     = pend_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Randomized and directed bench for seg_scan_mux against a cycle-count based
// reference model of the display schedule and the double-buffered value.
module tb_seg_scan_mux;
  localparam int P = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [31:0] value_in = '0;
  logic [7:0]  dp_in = '0;
  logic [7:0]  digit_en = 8'hFF;
  logic        blank_lz = 1'b0;
  logic [3:0]  nibble_out;
  logic [7:0]  an_out;
  logic        dp_out;
  logic [2:0]  digit_idx;
  logic        frame_start;
  logic        pending;

  seg_scan_mux #(.PRESCALE(P)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .value_in(value_in), .dp_in(dp_in),
    .digit_en(digit_en), .blank_lz(blank_lz), .nibble_out(nibble_out),
    .an_out(an_out), .dp_out(dp_out), .digit_idx(digit_idx),
    .frame_start(frame_start), .pending(pending)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: edges since reset, slot count, and the two value buffers.
  int          m_edges, m_slots, m_idx;
  logic [31:0] m_act, m_sh;
  logic [7:0]  m_adp, m_sdp;
  logic        m_pend;
  logic [7:0]  exp_an;
  logic [3:0]  exp_nib;
  logic        exp_dp, exp_fs;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_edges = 0; m_slots = 0; m_idx = 7;
    m_act = '0; m_sh = '0; m_adp = '0; m_sdp = '0; m_pend = 1'b0;
    exp_an = 8'hFF; exp_nib = 4'd0; exp_dp = 1'b1; exp_fs = 1'b0;
  endtask

  // Called at a rising edge: inputs are stable, so this sees what the DUT sees.
  task automatic model_step();
    bit tick, wrap;
    int msd;
    bit bl;
    tick = (m_edges % P) == (P - 1);
    m_edges++;
    wrap = 1'b0;
    if (tick) begin
      m_slots++;
      m_idx = (m_slots + 7) % 8;
      wrap = (m_idx == 0);
    end
    if (wrap && m_pend) begin
      m_act = m_sh; m_adp = m_sdp; m_pend = 1'b0;
    end
    if (load) begin
      m_sh = value_in; m_sdp = dp_in; m_pend = 1'b1;
    end
    exp_fs = wrap;
    if (tick) begin
      msd = 0;
      for (int i = 0; i < 8; i++)
        if (((m_act >> (4 * i)) & 32'hF) != 0 || m_adp[i]) msd = i;
      bl = !digit_en[m_idx] || (blank_lz && m_idx > msd);
      exp_nib = 4'((m_act >> (4 * m_idx)) & 32'hF);
      exp_an = 8'hFF;
      if (!bl) exp_an[m_idx] = 1'b0;
      exp_dp = bl ? 1'b1 : !m_adp[m_idx];
    end
  endtask

  task automatic compare_all();
    check("an_out", 32'(an_out), 32'(exp_an));
    check("nibble_out", 32'(nibble_out), 32'(exp_nib));
    check("dp_out", 32'(dp_out), 32'(exp_dp));
    check("digit_idx", 32'(digit_idx), 32'(m_idx));
    check("frame_start", 32'(frame_start), 32'(exp_fs));
    check("pending", 32'(pending), 32'(m_pend));
    check("an_onehot", 32'($countones(~an_out) <= 1), 32'd1);
  endtask

  // One clock cycle: called at a falling edge, returns at the next falling edge.
  task automatic cyc(input bit ld, input logic [31:0] v, input logic [7:0] dp);
    load = ld; value_in = v; dp_in = dp;
    @(posedge clk);
    model_step();
    @(negedge clk);
    load = 1'b0;
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, value_in, dp_in);
  endtask

  // Asynchronous reset pulse placed strictly between clock edges.
  task automatic async_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_an", 32'(an_out), 32'hFF);
    check("rst_dp", 32'(dp_out), 32'd1);
    check("rst_idx", 32'(digit_idx), 32'd7);
    check("rst_pend", 32'(pending), 32'd0);
    check("rst_fs", 32'(frame_start), 32'd0);
    check("rst_nib", 32'(nibble_out), 32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    compare_all();
  endtask

  task automatic wait_frame_start(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 10 * P * 8 && !seen; i++) begin
      cyc(1'b0, value_in, dp_in);
      seen = frame_start;
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    async_reset();
    // first tick four edges after release
    run(3);
    check("pre_tick_an", 32'(an_out), 32'hFF);
    run(1);
    check("first_fs", 32'(frame_start), 32'd1);
    check("first_an", 32'(an_out), 32'hFE);
    run(1);
    check("fs_one_cycle", 32'(frame_start), 32'd0);

    // full scan
    cyc(1'b1, 32'h1234ABCD, 8'h00);
    wait_frame_start("wait_scan");
    run(8 * P * 2);

    // leading-zero blanking
    blank_lz = 1'b1;
    cyc(1'b1, 32'h00000050, 8'h00);
    wait_frame_start("wait_lz1");
    run(8 * P);
    cyc(1'b1, 32'h0, 8'h00);
    wait_frame_start("wait_lz2");
    run(8 * P);
    cyc(1'b1, 32'h5, 8'h04);
    wait_frame_start("wait_lz3");
    run(8 * P);
    blank_lz = 1'b0;

    // tear-free update
    cyc(1'b1, 32'h11111111, 8'h00);
    wait_frame_start("wait_tear1");
    begin
      bit found = 1'b0;
      for (int i = 0; i < 8 * P * 2 && !found; i++) begin
        if (m_idx == 3) found = 1'b1;
        else cyc(1'b0, value_in, dp_in);
      end
      check("wait_idx3", 32'(found), 32'd1);
    end
    cyc(1'b1, 32'h22222222, 8'h00);
    check("tear_pend", 32'(pending), 32'd1);
    wait_frame_start("wait_tear2");
    check("tear_nib0", 32'(nibble_out), 32'd2);
    check("tear_pend0", 32'(pending), 32'd0);

    // load coincident with the wrap tick
    cyc(1'b1, 32'hAAAAAAAA, 8'h00);
    begin
      bit found = 1'b0;
      for (int i = 0; i < 8 * P * 2 && !found; i++) begin
        if ((m_edges % P) == P - 1 && m_idx == 7) found = 1'b1;
        else cyc(1'b0, value_in, dp_in);
      end
      check("wait_wrap", 32'(found), 32'd1);
    end
    cyc(1'b1, 32'hBBBBBBBB, 8'h00);
    check("coinc_fs", 32'(frame_start), 32'd1);
    check("coinc_nib", 32'(nibble_out), 32'hA);
    check("coinc_pend", 32'(pending), 32'd1);
    wait_frame_start("wait_coinc");
    check("coinc_nib2", 32'(nibble_out), 32'hB);
    check("coinc_pend2", 32'(pending), 32'd0);

    // digit_en mask
    digit_en = 8'h0F;
    cyc(1'b1, 32'h9876FEDC, 8'hF0);
    wait_frame_start("wait_mask");
    run(8 * P * 2);
    digit_en = 8'hFF;

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [31:0] v;
      logic [7:0] d;
      if ($urandom_range(0, 40) == 0) digit_en = 8'($urandom);
      if ($urandom_range(0, 30) == 0) blank_lz = ~blank_lz;
      v = $urandom >> $urandom_range(0, 31);
      d = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      if (i == 300) async_reset();
      cyc($urandom_range(0, 9) == 0, v, d);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
